// File: rtl/lsu_align.sv
// Load/store alignment unit in front of the data memory: aligned accesses pass
// through, misaligned word/half-word accesses are split into byte accesses.
`ifndef WIDTH_32
`define WIDTH_32  3'b000
`define WIDTH_16S 3'b001
`define WIDTH_16U 3'b010
`define WIDTH_8S  3'b011
`define WIDTH_8U  3'b100
`endif

module lsu_align #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_en_i,
  input  logic             we_i,
  input  logic [2:0]       width_src_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [WIDTH-1:0] dm_rd_i,
  output logic             dm_we_o,
  output logic [2:0]       dm_width_src_o,
  output logic [WIDTH-1:0] dm_addr_o,
  output logic [WIDTH-1:0] dm_wd_o,
  output logic [WIDTH-1:0] rd_o,
  output logic             stall_o,
  output logic             misaligned_o
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t           state_reg;
  logic [1:0]       k_reg;
  logic [WIDTH-1:0] asm_reg;

  logic             is_w32, is_w16, is_w8, is_signed;
  logic             req, split, last;
  logic [1:0]       k_last, k_cur;
  logic [WIDTH-1:0] asm_mix, raw;

  always_comb begin
    is_w32       = (width_src_i == `WIDTH_32);
    is_w16       = (width_src_i == `WIDTH_16S) || (width_src_i == `WIDTH_16U);
    is_w8        = (width_src_i == `WIDTH_8S) || (width_src_i == `WIDTH_8U);
    is_signed    = (width_src_i == `WIDTH_16S) || (width_src_i == `WIDTH_8S);
    // An unknown width code behaves like no memory operation at all.
    req          = mem_en_i && (is_w32 || is_w16 || is_w8);
    misaligned_o = req && ((is_w32 && (addr_i[1:0] != 2'b00)) || (is_w16 && addr_i[0]));
    split        = misaligned_o && !rst_i;
    k_last       = is_w32 ? 2'd3 : 2'd1;
    k_cur        = (state_reg == SPLIT) ? k_reg : 2'd0;
    last         = (k_cur == k_last);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      k_reg     <= 2'd0;
      asm_reg   <= '0;
    end else if (split && !last) begin
      state_reg <= SPLIT;
      k_reg     <= k_cur + 2'd1;
      asm_reg[{k_cur, 3'b000} +: 8] <= dm_rd_i[7:0];
    end else begin
      state_reg <= IDLE;
      k_reg     <= 2'd0;
      asm_reg   <= '0;
    end
  end

  always_comb begin
    dm_addr_o = addr_i;
    dm_wd_o   = wd_i;
    dm_we_o   = req && we_i && !rst_i;
    stall_o   = 1'b0;
    if (is_w16)     dm_width_src_o = `WIDTH_16S;
    else if (is_w8) dm_width_src_o = `WIDTH_8S;
    else            dm_width_src_o = `WIDTH_32;
    if (split) begin
      dm_width_src_o = `WIDTH_8S;
      dm_addr_o      = addr_i + WIDTH'(k_cur);
      dm_wd_o        = {{(WIDTH-8){1'b0}}, wd_i[{k_cur, 3'b000} +: 8]};
      dm_we_o        = we_i;
      stall_o        = !last;
    end
  end

  // The final byte of a split load bypasses the collect register.
  always_comb begin
    asm_mix = asm_reg;
    asm_mix[{k_last, 3'b000} +: 8] = dm_rd_i[7:0];
    raw  = split ? asm_mix : dm_rd_i;
    rd_o = '0;
    if (req && !we_i && !rst_i) begin
      if (is_w32)      rd_o = raw;
      else if (is_w16) rd_o = {{(WIDTH-16){is_signed & raw[15]}}, raw[15:0]};
      else             rd_o = {{(WIDTH-8){is_signed & raw[7]}}, raw[7:0]};
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Randomized self-checking bench for lsu_align against a byte-memory reference
// model, with directed alignment, wrap-around and reset-abort scenarios.
`timescale 1ns/1ps
`ifndef WIDTH_32
`define WIDTH_32  3'b000
`define WIDTH_16S 3'b001
`define WIDTH_16U 3'b010
`define WIDTH_8S  3'b011
`define WIDTH_8U  3'b100
`endif

module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  width_src = `WIDTH_32;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] dm_rd;
  logic        dm_we;
  logic [2:0]  dm_width;
  logic [31:0] dm_addr, dm_wd, rd;
  logic        stall, misaligned;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lsu_align #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .mem_en_i(mem_en), .we_i(we),
    .width_src_i(width_src), .addr_i(addr), .wd_i(wd), .dm_rd_i(dm_rd),
    .dm_we_o(dm_we), .dm_width_src_o(dm_width), .dm_addr_o(dm_addr),
    .dm_wd_o(dm_wd), .rd_o(rd), .stall_o(stall), .misaligned_o(misaligned)
  );

  // Data memory seen by the DUT, and the reference memory of the model.
  logic [7:0]  dmem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int unsigned mem_gen = 0;

  function automatic logic [7:0] dmem_byte(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(dm_addr or dm_width or mem_gen) begin
    if (dm_width == `WIDTH_8S)
      dm_rd = {24'h0, dmem_byte(dm_addr)};
    else if (dm_width == `WIDTH_16S)
      dm_rd = {16'h0, dmem_byte(dm_addr + 32'd1), dmem_byte(dm_addr)};
    else
      dm_rd = {dmem_byte(dm_addr + 32'd3), dmem_byte(dm_addr + 32'd2),
               dmem_byte(dm_addr + 32'd1), dmem_byte(dm_addr)};
  end

  always @(posedge clk) begin
    if (dm_we) begin
      dmem[dm_addr] = dm_wd[7:0];
      if (dm_width != `WIDTH_8S) dmem[dm_addr + 32'd1] = dm_wd[15:8];
      if (dm_width == `WIDTH_32) begin
        dmem[dm_addr + 32'd2] = dm_wd[23:16];
        dmem[dm_addr + 32'd3] = dm_wd[31:24];
      end
      mem_gen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations, written by the driver just after posedge.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_mis, exp_we, chk_bus, chk_mis, chk_rd;
  logic [2:0]  exp_width;
  logic [31:0] exp_addr, exp_wd, exp_rd;

  always @(negedge clk) begin
    if (exp_valid) begin
      check("stall_o", {31'b0, stall}, {31'b0, exp_stall});
      check("dm_we_o", {31'b0, dm_we}, {31'b0, exp_we});
      if (chk_mis) check("misaligned_o", {31'b0, misaligned}, {31'b0, exp_mis});
      if (chk_bus) begin
        check("dm_addr_o", dm_addr, exp_addr);
        check("dm_width_src_o", {29'b0, dm_width}, {29'b0, exp_width});
        if (exp_we) check("dm_wd_o", dm_wd, exp_wd);
      end
      if (chk_rd) check("rd_o", rd, exp_rd);
    end
  end

  function automatic bit width_valid(input logic [2:0] ws);
    return ws inside {`WIDTH_32, `WIDTH_16S, `WIDTH_16U, `WIDTH_8S, `WIDTH_8U};
  endfunction

  function automatic int width_bytes(input logic [2:0] ws);
    if (ws == `WIDTH_32) return 4;
    if (ws == `WIDTH_16S || ws == `WIDTH_16U) return 2;
    return 1;
  endfunction

  task automatic txn(input logic en, input logic w, input logic [2:0] ws,
                     input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd_seen);
    bit          ok, active, mis;
    int          nb, ncyc;
    logic [31:0] val, ext;
    ok     = width_valid(ws);
    active = en && ok;
    nb     = width_bytes(ws);
    mis    = active && ((a % nb) != 0);
    ncyc   = mis ? nb : 1;
    val    = '0;
    for (int i = 0; i < nb; i++) val = val | (32'(ref_byte(a + 32'(i))) << (8 * i));
    if (ws == `WIDTH_16S)     ext = 32'($signed(val[15:0]));
    else if (ws == `WIDTH_8S) ext = 32'($signed(val[7:0]));
    else                      ext = val;
    rd_seen = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      mem_en = en; we = w; width_src = ws; addr = a; wd = d;
      exp_valid = 1'b1;
      exp_stall = (k < ncyc - 1);
      exp_mis   = mis;
      exp_we    = active && w;
      chk_bus   = ok;
      chk_mis   = 1'b1;
      if (mis) begin
        exp_addr  = a + 32'(k);
        exp_width = `WIDTH_8S;
        exp_wd    = (d >> (8 * k)) & 32'hFF;
      end else begin
        exp_addr  = a;
        exp_width = (nb == 4) ? `WIDTH_32 : (nb == 2) ? `WIDTH_16S : `WIDTH_8S;
        exp_wd    = d;
      end
      chk_rd = (k == ncyc - 1);
      exp_rd = (active && !w) ? ext : 32'h0;
      @(negedge clk);
      rd_seen = rd;
    end
    if (active && w)
      for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    $display("[TB] txn en=%0d we=%0d width=%0d addr=%h wd=%h cycles=%0d rd=%h",
             en, w, ws, a, d, ncyc, rd_seen);
  endtask

  logic [31:0] r;
  logic [2:0]  ws_tab [5];

  initial begin
    ws_tab[0] = `WIDTH_32; ws_tab[1] = `WIDTH_16S; ws_tab[2] = `WIDTH_16U;
    ws_tab[3] = `WIDTH_8S; ws_tab[4] = `WIDTH_8U;

    // Reset with a live misaligned request on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; mem_en = 1'b1; we = (i == 1); width_src = `WIDTH_32; addr = 32'h101;
      wd = 32'hDEADBEEF;
      exp_valid = 1'b1; exp_stall = 1'b0; exp_we = 1'b0; exp_mis = 1'b0;
      chk_bus = 1'b0; chk_mis = 1'b0; chk_rd = 1'b1; exp_rd = 32'h0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;
    exp_valid = 1'b0;

    // Directed scenarios with literal expectations.
    txn(1, 1, `WIDTH_32, 32'h100, 32'hAABBCCDD, r);
    txn(1, 0, `WIDTH_32, 32'h100, 32'h0, r);
    check("lw_aligned", r, 32'hAABBCCDD);
    txn(1, 1, `WIDTH_32, 32'h101, 32'hAABBCCDD, r);
    txn(1, 0, `WIDTH_32, 32'h100, 32'h0, r);
    check("lw_after_split_sw", r, 32'hBBCCDDDD);
    txn(1, 0, `WIDTH_32, 32'h101, 32'h0, r);
    check("lw_misaligned", r, 32'hAABBCCDD);
    txn(1, 1, `WIDTH_8S, 32'h103, 32'h80, r);
    txn(1, 1, `WIDTH_8U, 32'h104, 32'hFF, r);
    txn(1, 0, `WIDTH_16S, 32'h103, 32'h0, r);
    check("lh_misaligned", r, 32'hFFFFFF80);
    txn(1, 0, `WIDTH_16U, 32'h103, 32'h0, r);
    check("lhu_misaligned", r, 32'h0000FF80);
    txn(1, 1, `WIDTH_8S, 32'h102, 32'hF0, r);
    txn(1, 0, `WIDTH_8S, 32'h102, 32'h0, r);
    check("lb", r, 32'hFFFFFFF0);
    txn(1, 0, `WIDTH_8U, 32'h102, 32'h0, r);
    check("lbu", r, 32'h000000F0);
    txn(1, 1, `WIDTH_32, 32'hFFFFFFFE, 32'h44332211, r);
    txn(1, 0, `WIDTH_32, 32'hFFFFFFFE, 32'h0, r);
    check("lw_wrap", r, 32'h44332211);
    txn(1, 0, 3'b111, 32'h100, 32'h0, r);
    check("invalid_width_rd", r, 32'h0);
    txn(1, 1, 3'b110, 32'h101, 32'h12345678, r);

    // Reset in cycle 1 of a misaligned store: only byte 0 lands.
    txn(0, 0, `WIDTH_32, 32'h300, 32'h0, r);
    @(posedge clk); #1;
    mem_en = 1'b1; we = 1'b1; width_src = `WIDTH_32; addr = 32'h301; wd = 32'h11223344;
    exp_valid = 1'b1; exp_stall = 1'b1; exp_we = 1'b1; exp_mis = 1'b1; chk_mis = 1'b1;
    chk_bus = 1'b1; exp_addr = 32'h301; exp_width = `WIDTH_8S; exp_wd = 32'h44; chk_rd = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_stall = 1'b0; exp_we = 1'b0; chk_bus = 1'b0; chk_mis = 1'b0;
    chk_rd = 1'b1; exp_rd = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;
    exp_valid = 1'b0;
    ref_mem[32'h301] = 8'h44;
    $display("[TB] txn reset-abort of misaligned sw at 00000301");
    txn(1, 0, `WIDTH_32, 32'h300, 32'h0, r);
    check("lw_after_reset_abort", r, 32'h00004400);

    // Randomized traffic, including back-to-back splits and wrap-around.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  ws;
      logic [31:0] a;
      ws = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : ws_tab[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 9) < 7) ? 32'h400 + 32'($urandom_range(0, 63))
                                      : 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
      txn(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, ws, a, $urandom, r);
    end

    exp_valid = 1'b0;
    @(posedge clk); #1;
    mem_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
